sar_result_buffer: RTL and testbench
====================================

# sar_result_buffer

Downstream stage of the SAR ADC conversion engine. It issues `ADC_start` while running, captures each 8-bit result on the `ADC_done` strobe, and optionally averages 2^AVG_LOG2 consecutive results with round-half-up. It queues the results in a first-word-fall-through FIFO that a consumer drains over a valid/ready handshake. It runs on the comparator clock so that it samples the conversion engine's outputs directly.

## Interface
Parameters:
- `DATA_W`, 8: result width; matches the ADC result width.
- `AVG_LOG2`, 2: log2 of the averaging window (1..4).
- `FIFO_DEPTH`, 8: FIFO entries; must be a power of 2, at least 2.

Ports:
- `clk_comp` in 1: comparator clock; the only clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `run` in 1: level; enables conversion triggering.
- `avg_en` in 1: averaging enable; sampled only on the IDLE->ACQ transition.
- `clear` in 1: synchronous flush of the FIFO and `overflow`.
- `ADC_done` in 1: one-cycle result strobe from the conversion engine.
- `ADC_data` in DATA_W: conversion result, valid when `ADC_done`=1.
- `ADC_start` out 1: registered conversion request to the conversion engine.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out DATA_W: FIFO head.
- `level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky; a result was dropped.

## Operation
- FSM states:
  - S_IDLE: `ADC_start`=0; accumulator and count cleared. `run`=1 -> S_ACQ, latching `avg_en` into `avg_mode`.
  - S_ACQ: `ADC_start`=1. `run`=0 -> S_IDLE. If `level`==FIFO_DEPTH and there is no pop that cycle -> S_HOLD.
  - S_HOLD: `ADC_start`=0; accumulation continues. `run`=0 -> S_IDLE. `level`<FIFO_DEPTH -> S_ACQ.
- Capture, on `ADC_done`=1 in S_ACQ or S_HOLD:
  - `avg_mode`=0: push `ADC_data` directly.
  - `avg_mode`=1: add to an accumulator of width DATA_W+AVG_LOG2 and increment `cnt`.
  - When `cnt`==2^AVG_LOG2-1, push `(acc+ADC_data+2^(AVG_LOG2-1))>>AVG_LOG2`, then clear `acc` and `cnt`. The result never exceeds 2^DATA_W-1, so no saturation is needed.
- `ADC_done` in S_IDLE is ignored; it does not set `overflow`.
- Push when full with no simultaneous pop: the value is dropped and `overflow` is set.
- Push when full with a simultaneous pop: both are performed and `level` stays at FIFO_DEPTH.
- Pop: `out_valid` && `out_ready`.
- FIFO: read and write pointers of $clog2(FIFO_DEPTH) bits, wrapping naturally.
- `run` falling mid-window: the partial accumulation is discarded; FIFO contents are retained.
- `clear`:
  - Empties the FIFO, zeroes `overflow`, `acc` and `cnt`.
  - FSM state is unchanged, except S_HOLD -> S_ACQ.
  - `clear` has priority over a same-cycle push or pop.
- Reset values: `ADC_start`=0, `out_valid`=0, `out_data`=0, `level`=0, `overflow`=0, FSM=S_IDLE, pointers, `acc` and `cnt`=0.
- Reset asserted mid-operation: all state returns to reset values immediately, and FIFO contents are lost.

## Timing
- `ADC_start` is a register and changes on the edge after the state transition is decided.
- `ADC_done` sampled at edge k with a push into an empty FIFO: `out_valid`=1 and `out_data` valid after edge k, so they are visible in cycle k+1.
- Pop at edge k: the next entry, or `out_valid`=0, is visible after edge k.
- `level` reflects push and pop of edge k after edge k.
- Full detection uses the post-edge `level`. S_HOLD is entered on the same edge as the push that fills the FIFO, so `ADC_start` drops one cycle after full.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `sar_pkg`:
  - State enum {S_IDLE, S_ACQ, S_HOLD}.
  - `ADC_DATA_W`=8.
  - Helper constant for the accumulator width.
- One sub-module, `sync_fifo_fwft`, parameterised by width and depth. It provides push, pop, full, empty, level and clear, and is reusable elsewhere.
- The top level holds the FSM, the accumulator/averager and the overflow logic.

## Test plan
- `avg_en`=0, `run`=1; results 0x12, 0x34, 0x56 -> FIFO outputs 0x12, 0x34, 0x56 in order; `out_valid` one cycle after each `ADC_done`.
- `avg_en`=1, AVG_LOG2=2:
  - Results 10, 11, 11, 11 -> single output 11, since (43+2)>>2=11.
  - Four results of 0xFF -> output 0xFF.
- FIFO_DEPTH=8, `out_ready`=0:
  - 8 results -> `level`=8, FSM in S_HOLD, `ADC_start`=0.
  - 9th result -> dropped, `overflow`=1.
  - Pop -> S_ACQ, `ADC_start`=1.
- Full FIFO, push and pop in the same cycle -> `level` stays 8, no overflow; the head advances and the new value lands at the tail.
- `run` dropped after 2 of 4 averaging samples -> no output; restart gives a clean 4-sample window. `clear` with 3 entries and `overflow`=1 -> `level`=0, `overflow`=0, `out_valid`=0.
- `Reset_n` asserted mid-window with a non-empty FIFO -> all outputs at reset values immediately, asynchronously; after release the FSM is in S_IDLE.

Source files
------------

// File: rtl/sar_result_buffer_pkg.sv
// Shared types and constants for the SAR result buffer and its neighbours.
// The package is named sar_pkg so other SAR blocks can import it too.
package sar_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_HOLD
  } state_e;

  localparam int ADC_DATA_W   = 8;
  localparam int AVG_LOG2_DEF = 2;

  // Wide enough to hold the sum of a full averaging window without wrapping.
  function automatic int acc_width(input int data_w, input int avg_log2);
    return data_w + avg_log2;
  endfunction

  localparam int ACC_W_DEF = acc_width(ADC_DATA_W, AVG_LOG2_DEF);

endpackage

// File: rtl/sar_result_buffer_if.sv
// Bundle of the conversion-engine, control and consumer-side signals of the result buffer.
interface sar_result_buffer_if #(
  parameter int DATA_W     = sar_pkg::ADC_DATA_W,
  parameter int FIFO_DEPTH = 8
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               run;
  logic               avg_en;
  logic               clear;
  logic               ADC_done;
  logic [DATA_W-1:0]  ADC_data;
  logic               ADC_start;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [LEVEL_W-1:0] level;
  logic               overflow;

  modport master (
    output run, avg_en, clear, ADC_done, ADC_data, out_ready,
    input  ADC_start, out_valid, out_data, level, overflow
  );

  modport slave (
    input  run, avg_en, clear, ADC_done, ADC_data, out_ready,
    output ADC_start, out_valid, out_data, level, overflow
  );

endinterface

// File: rtl/sar_result_buffer_fifo.sv
// First-word-fall-through synchronous FIFO; the head is visible whenever it is non-empty.
// A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [$clog2(DEPTH):0] level_nxt_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               do_push;
  logic               do_pop;

  assign full_o      = (level_q == LEVEL_W'(DEPTH));
  assign empty_o     = (level_q == '0);
  assign do_pop      = pop_i && !empty_o && !clear_i;
  assign do_push     = push_i && (!full_o || do_pop) && !clear_i;
  assign rdata_o     = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o     = level_q;
  assign level_nxt_o = level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LEVEL_W'(1);
        2'b01:   level_d = level_q - LEVEL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the read path is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sar_result_buffer.sv
// Triggers SAR conversions, optionally averages 2^AVG_LOG2 results with round-half-up,
// and queues them for a valid/ready consumer; runs on the comparator clock.
module sar_result_buffer
  import sar_pkg::*;
#(
  parameter int DATA_W     = ADC_DATA_W,
  parameter int AVG_LOG2   = AVG_LOG2_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input logic                clk_comp,
  input logic                Reset_n,
  sar_result_buffer_if.slave bus
);

  localparam int                 ACC_W    = acc_width(DATA_W, AVG_LOG2);
  localparam int                 LEVEL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(FIFO_DEPTH);
  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;
  localparam logic [ACC_W-1:0]   HALF     = ACC_W'(1) << (AVG_LOG2 - 1);

  state_e              state_q, state_d;
  logic                avg_mode_q, avg_mode_d;
  logic                start_q;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic                overflow_q, overflow_d;

  logic                push_req;
  logic [DATA_W-1:0]   push_data;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LEVEL_W-1:0]  level;
  logic [LEVEL_W-1:0]  level_nxt;
  logic [DATA_W-1:0]   head;

  assign pop = !fifo_empty && bus.out_ready;

  sync_fifo_fwft #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk_comp),
    .rst_n       (Reset_n),
    .clear_i     (bus.clear),
    .push_i      (push_req),
    .wdata_i     (push_data),
    .pop_i       (pop),
    .rdata_o     (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level),
    .level_nxt_o (level_nxt)
  );

  assign bus.ADC_start = start_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head;
  assign bus.level     = level;
  assign bus.overflow  = overflow_q;

  // Full detection looks at the post-edge level so HOLD starts on the filling edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.run) state_d = S_ACQ;
      S_ACQ: begin
        if (!bus.run) state_d = S_IDLE;
        else if (level_nxt == FULL_LVL && !pop) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!bus.run) state_d = S_IDLE;
        else if (level_nxt != FULL_LVL) state_d = S_ACQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    push_req   = 1'b0;
    push_data  = bus.ADC_data;
    avg_mode_d = avg_mode_q;
    if (state_q == S_IDLE && bus.run) avg_mode_d = bus.avg_en;
    if (bus.clear || state_q == S_IDLE) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (bus.ADC_done) begin
      if (!avg_mode_q) begin
        push_req = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        push_req  = 1'b1;
        push_data = DATA_W'((acc_q + ACC_W'(bus.ADC_data) + HALF) >> AVG_LOG2);
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = acc_q + ACC_W'(bus.ADC_data);
        cnt_d = cnt_q + AVG_LOG2'(1);
      end
    end
    overflow_d = bus.clear ? 1'b0 : (overflow_q | (push_req && fifo_full && !pop));
  end

  always_ff @(posedge clk_comp or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      avg_mode_q <= 1'b0;
      start_q    <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      avg_mode_q <= avg_mode_d;
      start_q    <= (state_q == S_ACQ);
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_sar_result_buffer.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based behavioural model.
module tb_sar_result_buffer;

  localparam int DW    = 8;
  localparam int AL    = 2;
  localparam int N     = 1 << AL;
  localparam int DEPTH = 8;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_HOLD = 2;

  logic clk_comp = 1'b0;
  logic Reset_n  = 1'b0;

  int checks   = 0;
  int failures = 0;

  sar_result_buffer_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus();

  sar_result_buffer #(
    .DATA_W     (DW),
    .AVG_LOG2   (AL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_comp (clk_comp),
    .Reset_n  (Reset_n),
    .bus      (bus)
  );

  always #5 clk_comp = ~clk_comp;

  int unsigned mq[$];
  int unsigned win[$];
  bit          m_ovf   = 1'b0;
  bit          m_start = 1'b0;
  bit          m_avg   = 1'b0;
  int          m_state = M_IDLE;

  // Reference: results are a list, an averaging window is a list of samples.
  function automatic void modelStep();
    bit          pop;
    bit          have;
    bit          fullBefore;
    int unsigned val;
    int unsigned sum;
    int          post;
    pop  = (mq.size() > 0) && bus.out_ready;
    have = 1'b0;
    val  = 0;
    if (bus.clear) begin
      mq.delete();
      win.delete();
      m_ovf = 1'b0;
    end else begin
      if (m_state == M_IDLE) begin
        win.delete();
      end else if (bus.ADC_done) begin
        if (!m_avg) begin
          have = 1'b1;
          val  = bus.ADC_data;
        end else begin
          win.push_back(bus.ADC_data);
          if (win.size() == N) begin
            sum = 0;
            foreach (win[i]) sum += win[i];
            val  = (sum + N / 2) / N;
            have = 1'b1;
            win.delete();
          end
        end
      end
      fullBefore = (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      if (have) begin
        if (fullBefore && !pop) m_ovf = 1'b1;
        else mq.push_back(val);
      end
    end
    post    = mq.size();
    m_start = (m_state == M_ACQ);
    case (m_state)
      M_IDLE: if (bus.run) begin
        m_state = M_ACQ;
        m_avg   = bus.avg_en;
      end
      M_ACQ: begin
        if (!bus.run) m_state = M_IDLE;
        else if (post == DEPTH && !pop) m_state = M_HOLD;
      end
      default: begin
        if (!bus.run) m_state = M_IDLE;
        else if (post < DEPTH) m_state = M_ACQ;
      end
    endcase
  endfunction

  always @(posedge clk_comp or negedge Reset_n) begin
    if (!Reset_n) begin
      mq.delete();
      win.delete();
      m_ovf   = 1'b0;
      m_start = 1'b0;
      m_avg   = 1'b0;
      m_state = M_IDLE;
    end else begin
      modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_comp) begin
    checkOutput("cmp_ADC_start", 32'(bus.ADC_start), 32'(m_start));
    checkOutput("cmp_out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
    checkOutput("cmp_level", 32'(bus.level), 32'(mq.size()));
    checkOutput("cmp_overflow", 32'(bus.overflow), 32'(m_ovf));
    if (mq.size() > 0) checkOutput("cmp_out_data", 32'(bus.out_data), mq[0]);
  end

  task automatic applyStimulus(input bit r, input bit a, input bit c, input bit d,
                               input logic [7:0] data, input bit rdy);
    bus.run       = r;
    bus.avg_en    = a;
    bus.clear     = c;
    bus.ADC_done  = d;
    bus.ADC_data  = data;
    bus.out_ready = rdy;
    @(negedge clk_comp);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ADC_start"}, 32'(bus.ADC_start), 0);
    checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    checkOutput({tag, "_out_data"}, 32'(bus.out_data), 0);
    checkOutput({tag, "_level"}, 32'(bus.level), 0);
    checkOutput({tag, "_overflow"}, 32'(bus.overflow), 0);
  endtask

  task automatic midCycleReset(input string tag);
    bus.run = 0; bus.avg_en = 0; bus.clear = 0; bus.ADC_done = 0; bus.out_ready = 0;
    #2 Reset_n = 1'b0;
    #1 checkResetOutputs(tag);
    @(negedge clk_comp);
    Reset_n = 1'b1;
  endtask

  initial begin
    bit pRun;
    int readyPct;
    bus.run = 0; bus.avg_en = 0; bus.clear = 0; bus.ADC_done = 0;
    bus.ADC_data = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk_comp);
    checkResetOutputs("reset");
    Reset_n = 1'b1;

    // Pass-through mode: three results in order, then drained.
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 1, 8'h12, 0);
    checkOutput("pt_valid_after_done", 32'(bus.out_valid), 1);
    checkOutput("pt_first_data", 32'(bus.out_data), 32'h12);
    applyStimulus(1, 0, 0, 1, 8'h34, 0);
    applyStimulus(1, 0, 0, 1, 8'h56, 0);
    checkOutput("pt_level3", 32'(bus.level), 3);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("pt_second_data", 32'(bus.out_data), 32'h34);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("pt_third_data", 32'(bus.out_data), 32'h56);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("pt_drained_valid", 32'(bus.out_valid), 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 0);

    // Averaging: 10,11,11,11 -> 11 and four 0xFF -> 0xFF.
    applyStimulus(1, 1, 0, 0, 8'h00, 0);
    applyStimulus(1, 1, 0, 1, 8'd10, 0);
    applyStimulus(1, 1, 0, 1, 8'd11, 0);
    applyStimulus(1, 1, 0, 1, 8'd11, 0);
    checkOutput("avg_partial_level", 32'(bus.level), 0);
    applyStimulus(1, 1, 0, 1, 8'd11, 0);
    checkOutput("avg_level1", 32'(bus.level), 1);
    checkOutput("avg_round_11", 32'(bus.out_data), 11);
    applyStimulus(1, 1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 1, 8'hFF, 0);
    checkOutput("avg_max_ff", 32'(bus.out_data), 32'hFF);
    applyStimulus(1, 1, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0);

    // Fill to full, simultaneous push/pop at full, then overflow.
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 1, 8'(i * 16 + 1), 0);
    checkOutput("full_level8", 32'(bus.level), 8);
    applyStimulus(1, 0, 0, 1, 8'h99, 1);
    checkOutput("pushpop_level8", 32'(bus.level), 8);
    checkOutput("pushpop_no_ovf", 32'(bus.overflow), 0);
    checkOutput("pushpop_head", 32'(bus.out_data), 32'h11);
    checkOutput("hold_start0", 32'(bus.ADC_start), 0);
    applyStimulus(1, 0, 0, 1, 8'hEE, 0);
    checkOutput("ovf_set", 32'(bus.overflow), 1);
    checkOutput("ovf_level8", 32'(bus.level), 8);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    checkOutput("resume_start1", 32'(bus.ADC_start), 1);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkOutput("tail_is_99", 32'(bus.out_data), 32'h99);
    applyStimulus(1, 0, 0, 1, 8'h21, 0);
    applyStimulus(1, 0, 0, 1, 8'h22, 0);
    checkOutput("preclear_level3", 32'(bus.level), 3);
    applyStimulus(1, 0, 1, 0, 8'h00, 0);
    checkOutput("clear_level", 32'(bus.level), 0);
    checkOutput("clear_ovf", 32'(bus.overflow), 0);
    checkOutput("clear_valid", 32'(bus.out_valid), 0);

    // Run dropped mid-window discards the partial sum.
    applyStimulus(0, 0, 0, 0, 8'h00, 0);
    applyStimulus(1, 1, 0, 0, 8'h00, 0);
    applyStimulus(1, 1, 0, 1, 8'd40, 0);
    applyStimulus(1, 1, 0, 1, 8'd41, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    applyStimulus(1, 1, 0, 0, 8'h00, 0);
    for (int i = 4; i < 8; i++) applyStimulus(1, 1, 0, 1, 8'(i), 0);
    checkOutput("restart_level1", 32'(bus.level), 1);
    checkOutput("restart_avg6", 32'(bus.out_data), 6);

    // Asynchronous reset mid-window with a non-empty FIFO.
    applyStimulus(1, 1, 0, 1, 8'd50, 0);
    applyStimulus(1, 1, 0, 1, 8'd60, 0);
    midCycleReset("midrst");
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    checkOutput("postrst_start_still0", 32'(bus.ADC_start), 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    checkOutput("postrst_start1", 32'(bus.ADC_start), 1);

    // Random traffic; readiness alternates between starved and generous phases.
    readyPct = 10;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) readyPct = (readyPct == 10) ? 60 : 10;
      if (i == 2000) midCycleReset("rndrst");
      pRun = ($urandom_range(0, 99) < 95);
      applyStimulus(pRun,
                    (pRun ? bus.avg_en : 1'($urandom_range(0, 1))),
                    ($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 35),
                    8'($urandom_range(0, 255)),
                    ($urandom_range(0, 99) < readyPct));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
